// File: rtl/pstprc_pkg.sv
// Shared types and default sizes for the post-processing sequencer.
package pstprc_pkg;

  localparam int unsigned NUM_CH = 12;
  localparam int unsigned WIN_W  = 15;
  localparam int unsigned DPS_W  = 16;
  localparam int unsigned IQ_W   = 64;
  localparam int unsigned CH_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_PUSH,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [WIN_W-1:0] winstart;
    logic [WIN_W-1:0] winln;
    logic [DPS_W-1:0] dps;
  } cfg_entry_t;

endpackage

// File: rtl/pstprc_cfg_table.sv
// Per-channel configuration register file: one write port, combinational read.
module pstprc_cfg_table
  import pstprc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [CH_W-1:0] wr_addr,
  input  cfg_entry_t      wr_data,
  input  logic [CH_W-1:0] rd_addr,
  output cfg_entry_t      rd_data
);

  cfg_entry_t entries [NUM_CH];

  // Writes to indices beyond the table are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        entries[i] <= '0;
      end
    end else if (wr_en && (wr_addr < CH_W'(NUM_CH))) begin
      entries[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_addr < CH_W'(NUM_CH)) begin
      rd_data = entries[rd_addr];
    end
  end

endmodule

// File: rtl/pstprc_seq_ctrl.sv
// Walks the channel table per sample trigger, drives Dmod_Seg and pushes
// each IQ result with its channel index into the post-processing FIFO.
module pstprc_seq_ctrl
  import pstprc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             posedge_sample_trig,
  input  logic [15:0]      cmd_smpl_depth,
  input  logic             pstprc_num_en,
  input  logic [CH_W-1:0]  Pstprc_num,
  input  logic             cfg_wr_en,
  input  logic [CH_W-1:0]  cfg_wr_addr,
  input  logic [WIN_W-1:0] cfg_winstart,
  input  logic [WIN_W-1:0] cfg_winln,
  input  logic [DPS_W-1:0] cfg_dps,
  output logic [WIN_W-1:0] demoWinstart_twelve,
  output logic [WIN_W-1:0] demoWinln_twelve,
  output logic [DPS_W-1:0] Pstprc_DPS_twelve,
  output logic             seg_start,
  input  logic             Pstprc_finish,
  input  logic [IQ_W-1:0]  pstprc_IQ_seq_o,
  output logic             pstprc_fifo_wren,
  output logic [IQ_W-1:0]  pstprc_fifo_din,
  output logic [CH_W-1:0]  pstprc_fifo_ch,
  input  logic             pstprc_fifo_full,
  output logic             busy,
  output logic             frame_done,
  input  logic             err_clr,
  output logic             err_win,
  output logic             err_timeout,
  output logic             trig_overrun
);

  localparam int unsigned TMR_W   = $clog2(TIMEOUT + 1);
  localparam int unsigned DEPTH_W = 16;
  localparam int unsigned CHK_W   = 17;

  state_t            state;
  logic [CH_W-1:0]   num_reg;
  logic [CH_W-1:0]   ch;
  logic [DEPTH_W-1:0] depth_q;
  logic [TMR_W-1:0]  timer;
  logic [IQ_W-1:0]   iq_hold;

  cfg_entry_t        entry;
  cfg_entry_t        wr_entry;
  logic              cfg_we;
  logic              win_bad;
  logic              last_ch;
  logic [CHK_W-1:0]  win_end;
  logic [CH_W-1:0]   num_sat;

  assign cfg_we   = cfg_wr_en && (state == ST_IDLE);
  assign wr_entry = '{winstart: cfg_winstart, winln: cfg_winln, dps: cfg_dps};

  pstprc_cfg_table u_cfg_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (cfg_we),
    .wr_addr (cfg_wr_addr),
    .wr_data (wr_entry),
    .rd_addr (ch),
    .rd_data (entry)
  );

  // Window sum widened so start + length cannot wrap before the depth compare
  always_comb begin
    win_end = CHK_W'(entry.winstart) + CHK_W'(entry.winln);
    win_bad = (entry.winln == '0) || (win_end > CHK_W'(depth_q));
    last_ch = (ch == (num_reg - CH_W'(1)));
    num_sat = (Pstprc_num > CH_W'(NUM_CH)) ? CH_W'(NUM_CH) : Pstprc_num;
  end

  // Outputs are registered alongside the transition into the state they belong to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= ST_IDLE;
      num_reg             <= '0;
      ch                  <= '0;
      depth_q             <= '0;
      timer               <= '0;
      iq_hold             <= '0;
      demoWinstart_twelve <= '0;
      demoWinln_twelve    <= '0;
      Pstprc_DPS_twelve   <= '0;
      seg_start           <= 1'b0;
      pstprc_fifo_wren    <= 1'b0;
      pstprc_fifo_din     <= '0;
      pstprc_fifo_ch      <= '0;
      busy                <= 1'b0;
      frame_done          <= 1'b0;
      err_win             <= 1'b0;
      err_timeout         <= 1'b0;
      trig_overrun        <= 1'b0;
    end else begin
      seg_start        <= 1'b0;
      pstprc_fifo_wren <= 1'b0;
      frame_done       <= 1'b0;

      // Clear first so a same-cycle set event below takes priority
      if (err_clr) begin
        err_win      <= 1'b0;
        err_timeout  <= 1'b0;
        trig_overrun <= 1'b0;
      end
      if (posedge_sample_trig && (state != ST_IDLE)) begin
        trig_overrun <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (pstprc_num_en) begin
            num_reg <= num_sat;
          end
          if (posedge_sample_trig && (num_reg != '0)) begin
            depth_q <= cmd_smpl_depth;
            ch      <= '0;
            busy    <= 1'b1;
            state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          demoWinstart_twelve <= entry.winstart;
          demoWinln_twelve    <= entry.winln;
          Pstprc_DPS_twelve   <= entry.dps;
          if (win_bad) begin
            err_win <= 1'b1;
            if (last_ch) begin
              frame_done <= 1'b1;
              state      <= ST_DONE;
            end else begin
              ch    <= ch + CH_W'(1);
              state <= ST_LOAD;
            end
          end else begin
            seg_start <= 1'b1;
            state     <= ST_START;
          end
        end
        ST_START: begin
          timer <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (Pstprc_finish) begin
            iq_hold <= pstprc_IQ_seq_o;
            state   <= ST_PUSH;
          end else if (timer == TMR_W'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            frame_done  <= 1'b1;
            state       <= ST_DONE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        ST_PUSH: begin
          if (!pstprc_fifo_full) begin
            pstprc_fifo_wren <= 1'b1;
            pstprc_fifo_din  <= iq_hold;
            pstprc_fifo_ch   <= ch;
            if (last_ch) begin
              frame_done <= 1'b1;
              state      <= ST_DONE;
            end else begin
              ch    <= ch + CH_W'(1);
              state <= ST_LOAD;
            end
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pstprc_seq_ctrl.sv
// Randomized frame-level bench for pstprc_seq_ctrl with a Dmod_Seg responder and FIFO scoreboard.
module tb_pstprc_seq_ctrl;
  import pstprc_pkg::*;

  localparam int TMO = 50;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              posedge_sample_trig = 1'b0;
  logic [15:0]       cmd_smpl_depth = '0;
  logic              pstprc_num_en = 1'b0;
  logic [3:0]        Pstprc_num = '0;
  logic              cfg_wr_en = 1'b0;
  logic [3:0]        cfg_wr_addr = '0;
  logic [WIN_W-1:0]  cfg_winstart = '0;
  logic [WIN_W-1:0]  cfg_winln = '0;
  logic [DPS_W-1:0]  cfg_dps = '0;
  logic [WIN_W-1:0]  demoWinstart_twelve;
  logic [WIN_W-1:0]  demoWinln_twelve;
  logic [DPS_W-1:0]  Pstprc_DPS_twelve;
  logic              seg_start;
  logic              Pstprc_finish = 1'b0;
  logic [IQ_W-1:0]   pstprc_IQ_seq_o = '0;
  logic              pstprc_fifo_wren;
  logic [IQ_W-1:0]   pstprc_fifo_din;
  logic [3:0]        pstprc_fifo_ch;
  logic              pstprc_fifo_full = 1'b0;
  logic              busy;
  logic              frame_done;
  logic              err_clr = 1'b0;
  logic              err_win;
  logic              err_timeout;
  logic              trig_overrun;

  always #5 clk = ~clk;

  pstprc_seq_ctrl #(.TIMEOUT(TMO)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .posedge_sample_trig (posedge_sample_trig),
    .cmd_smpl_depth      (cmd_smpl_depth),
    .pstprc_num_en       (pstprc_num_en),
    .Pstprc_num          (Pstprc_num),
    .cfg_wr_en           (cfg_wr_en),
    .cfg_wr_addr         (cfg_wr_addr),
    .cfg_winstart        (cfg_winstart),
    .cfg_winln           (cfg_winln),
    .cfg_dps             (cfg_dps),
    .demoWinstart_twelve (demoWinstart_twelve),
    .demoWinln_twelve    (demoWinln_twelve),
    .Pstprc_DPS_twelve   (Pstprc_DPS_twelve),
    .seg_start           (seg_start),
    .Pstprc_finish       (Pstprc_finish),
    .pstprc_IQ_seq_o     (pstprc_IQ_seq_o),
    .pstprc_fifo_wren    (pstprc_fifo_wren),
    .pstprc_fifo_din     (pstprc_fifo_din),
    .pstprc_fifo_ch      (pstprc_fifo_ch),
    .pstprc_fifo_full    (pstprc_fifo_full),
    .busy                (busy),
    .frame_done          (frame_done),
    .err_clr             (err_clr),
    .err_win             (err_win),
    .err_timeout         (err_timeout),
    .trig_overrun        (trig_overrun)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Reference view of the configuration the DUT should hold
  int m_ws  [NUM_CH];
  int m_wl  [NUM_CH];
  int m_dps [NUM_CH];
  int m_num = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_outs(input string pfx);
    chk({pfx, "_winstart"}, 64'(demoWinstart_twelve), 64'(0));
    chk({pfx, "_winln"},    64'(demoWinln_twelve), 64'(0));
    chk({pfx, "_dps"},      64'(Pstprc_DPS_twelve), 64'(0));
    chk({pfx, "_seg"},      64'(seg_start), 64'(0));
    chk({pfx, "_wren"},     64'(pstprc_fifo_wren), 64'(0));
    chk({pfx, "_din"},      pstprc_fifo_din, 64'(0));
    chk({pfx, "_ch"},       64'(pstprc_fifo_ch), 64'(0));
    chk({pfx, "_busy"},     64'(busy), 64'(0));
    chk({pfx, "_done"},     64'(frame_done), 64'(0));
    chk({pfx, "_errwin"},   64'(err_win), 64'(0));
    chk({pfx, "_errtmo"},   64'(err_timeout), 64'(0));
    chk({pfx, "_ovr"},      64'(trig_overrun), 64'(0));
  endtask

  task automatic cfg_write(input int addr, input int ws, input int wl, input int dps);
    cfg_wr_en    = 1'b1;
    cfg_wr_addr  = 4'(addr);
    cfg_winstart = WIN_W'(ws);
    cfg_winln    = WIN_W'(wl);
    cfg_dps      = DPS_W'(dps);
    step();
    cfg_wr_en = 1'b0;
    if (addr < int'(NUM_CH)) begin
      m_ws[addr]  = ws;
      m_wl[addr]  = wl;
      m_dps[addr] = dps;
    end
  endtask

  task automatic num_write(input int n);
    pstprc_num_en = 1'b1;
    Pstprc_num    = 4'(n);
    step();
    pstprc_num_en = 1'b0;
    m_num = (n > int'(NUM_CH)) ? int'(NUM_CH) : n;
  endtask

  // One frame: predict starts/pushes/errors from the table, play Dmod_Seg and the FIFO
  task automatic run_frame(input int depth, input int fin_dly, input int tmo_ch,
                           input int bp_ch, input bit rnd_full, input bit inject);
    int          exp_start[$];
    int          exp_ch[$];
    logic [63:0] exp_iq[$];
    logic [63:0] iq_of[NUM_CH];
    logic [63:0] din_prev;
    logic [3:0]  ch_prev;
    bit exp_ew, exp_et, stop, ch0_good, first, push_wait, push_arm, full_prev, injected, exp_w;
    int k, s_step, fin_at, cur_ch, bp_left, done_step;

    exp_ew = 0; exp_et = 0; stop = 0; first = 1; push_wait = 0; push_arm = 0;
    full_prev = 0; injected = 0; s_step = -1; fin_at = -1; cur_ch = -1;
    bp_left = 0; done_step = -1;

    err_clr = 1'b1;
    step();
    err_clr = 1'b0;

    if (m_num == 0) begin
      cmd_smpl_depth = 16'(depth);
      posedge_sample_trig = 1'b1;
      step();
      posedge_sample_trig = 1'b0;
      for (int i = 0; i < 4; i++) begin
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_start", 64'(seg_start), 64'(0));
        step();
      end
      return;
    end

    for (int c = 0; c < m_num && !stop; c++) begin
      iq_of[c] = {$urandom, $urandom};
      if (m_wl[c] == 0 || (m_ws[c] + m_wl[c]) > depth) begin
        exp_ew = 1;
      end else begin
        exp_start.push_back(c);
        if (c == tmo_ch) begin
          exp_et = 1;
          stop = 1;
        end else begin
          exp_ch.push_back(c);
          exp_iq.push_back(iq_of[c]);
        end
      end
    end
    ch0_good = (exp_start.size() > 0) && (exp_start[0] == 0);

    cmd_smpl_depth = 16'(depth);
    posedge_sample_trig = 1'b1;
    step();
    posedge_sample_trig = 1'b0;
    k = 1;

    while (done_step < 0 && k < 4000) begin
      if (k == 1) chk("busy_set", 64'(busy), 64'(1));

      exp_w = push_wait && !full_prev;
      chk("wren", 64'(pstprc_fifo_wren), 64'(exp_w));
      if (pstprc_fifo_wren) begin
        if (exp_ch.size() == 0) begin
          chk("extra_write", 64'(pstprc_fifo_wren), 64'(0));
        end else begin
          chk("fifo_ch", 64'(pstprc_fifo_ch), 64'(exp_ch.pop_front()));
          chk("fifo_din", pstprc_fifo_din, exp_iq.pop_front());
        end
      end
      if (exp_w) push_wait = 1'b0;
      if (push_wait && full_prev) begin
        chk("stall_din", pstprc_fifo_din, din_prev);
        chk("stall_ch", 64'(pstprc_fifo_ch), 64'(ch_prev));
      end

      if (seg_start) begin
        if (first && ch0_good) chk("start_latency", 64'(k), 64'(2));
        first = 1'b0;
        if (exp_start.size() == 0) begin
          chk("extra_start", 64'(seg_start), 64'(0));
        end else begin
          cur_ch = exp_start.pop_front();
          chk("winstart", 64'(demoWinstart_twelve), 64'(m_ws[cur_ch]));
          chk("winln", 64'(demoWinln_twelve), 64'(m_wl[cur_ch]));
          chk("dps", 64'(Pstprc_DPS_twelve), 64'(m_dps[cur_ch]));
          s_step = k;
          if (cur_ch == tmo_ch) fin_at = -1;
          else fin_at = k + ((fin_dly > 0) ? fin_dly : int'($urandom_range(1, TMO)));
        end
      end

      if (s_step >= 0 && cur_ch == tmo_ch) begin
        if (k == s_step + TMO)     chk("tmo_early", 64'(err_timeout), 64'(0));
        if (k == s_step + TMO + 1) chk("tmo_set", 64'(err_timeout), 64'(1));
      end

      if (frame_done) done_step = k;

      if (push_arm) begin
        push_wait = 1'b1;
        push_arm  = 1'b0;
      end
      if (k == fin_at) begin
        Pstprc_finish   = 1'b1;
        pstprc_IQ_seq_o = iq_of[cur_ch];
        push_arm        = 1'b1;
        if (cur_ch == bp_ch) bp_left = 10;
      end else begin
        Pstprc_finish   = 1'b0;
        pstprc_IQ_seq_o = {$urandom, $urandom};
      end
      if (bp_left > 0) begin
        pstprc_fifo_full = 1'b1;
        bp_left--;
      end else begin
        pstprc_fifo_full = rnd_full && ($urandom_range(0, 3) == 0);
      end

      if (inject && !injected && s_step >= 0 && k == s_step + 3) begin
        posedge_sample_trig = 1'b1;
        cfg_wr_en     = 1'b1;
        cfg_wr_addr   = 4'd0;
        cfg_winstart  = 15'h7ABC;
        cfg_winln     = 15'h0001;
        cfg_dps       = 16'hDEAD;
        pstprc_num_en = 1'b1;
        Pstprc_num    = 4'd1;
        injected      = 1'b1;
      end else begin
        posedge_sample_trig = 1'b0;
        cfg_wr_en     = 1'b0;
        pstprc_num_en = 1'b0;
      end

      full_prev = pstprc_fifo_full;
      din_prev  = pstprc_fifo_din;
      ch_prev   = pstprc_fifo_ch;
      step();
      k++;
    end

    Pstprc_finish    = 1'b0;
    pstprc_fifo_full = 1'b0;
    posedge_sample_trig = 1'b0;
    cfg_wr_en        = 1'b0;
    pstprc_num_en    = 1'b0;

    if (done_step < 0) chk("frame_end", 64'(frame_done), 64'(1));
    chk("starts_left", 64'(exp_start.size()), 64'(0));
    chk("writes_left", 64'(exp_ch.size()), 64'(0));
    chk("err_win", 64'(err_win), 64'(exp_ew));
    chk("err_timeout", 64'(err_timeout), 64'(exp_et));
    chk("trig_overrun", 64'(trig_overrun), 64'(inject));
    chk("busy_clr", 64'(busy), 64'(0));
    chk("done_pulse", 64'(frame_done), 64'(0));
  endtask

  initial begin
    int depth, n, ws, wl;
    bit big;

    for (int i = 0; i < int'(NUM_CH); i++) begin
      m_ws[i] = 0; m_wl[i] = 0; m_dps[i] = 0;
    end

    #2;
    chk_zero_outs("reset");
    step();
    rst_n = 1'b1;
    step();

    // Basic frame, last entry exactly fills the capture depth
    num_write(3);
    cfg_write(0, 'h010, 'h5DC, 'h1234);
    cfg_write(1, 'h100, 'h200, 'h0000);
    cfg_write(2, 'h000, 'h7D0, 'hFFFF);
    run_frame('h7D0, 20, -1, -1, 1'b0, 1'b0);

    // Zero length and one-past-depth windows are skipped
    cfg_write(1, 'h100, 'h000, 'h0055);
    cfg_write(2, 'h700, 'h0D1, 'h0066);
    run_frame('h7D0, 0, -1, -1, 1'b0, 1'b0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_clr", 64'(err_win), 64'(0));

    // Backpressure on channel 1, then timeout on channel 0
    cfg_write(1, 'h100, 'h200, 'h0000);
    cfg_write(2, 'h000, 'h7D0, 'hFFFF);
    run_frame('h7D0, 0, -1, 1, 1'b0, 1'b0);
    run_frame('h7D0, 0, 0, -1, 1'b0, 1'b0);

    // Trigger/config during a frame, then confirm table and count unchanged
    run_frame('h7D0, 20, -1, -1, 1'b0, 1'b1);
    run_frame('h7D0, 0, -1, -1, 1'b1, 1'b0);

    for (int f = 0; f < 16; f++) begin
      big   = ($urandom_range(0, 3) == 0);
      depth = big ? int'($urandom_range(16'h8000, 16'hFFFF)) : int'($urandom_range(400, 2500));
      num_write(int'($urandom_range(0, 15)));
      repeat ($urandom_range(3, 10)) begin
        ws = big ? int'($urandom_range(0, 15'h7FFF)) : int'($urandom_range(0, 1500));
        wl = big ? int'($urandom_range(1, 15'h7FFF)) : int'($urandom_range(1, 1200));
        if ($urandom_range(0, 7) == 0) wl = 0;
        if ($urandom_range(0, 5) == 0 && depth > ws && (depth - ws) < 'h8000) wl = depth - ws;
        cfg_write(int'($urandom_range(0, 15)), ws, wl, int'($urandom_range(0, 16'hFFFF)));
      end
      run_frame(depth, 0, ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 11)) : -1,
                -1, 1'b1, 1'b0);
    end

    // Reset while stalled in PUSH
    num_write(2);
    cfg_write(0, 16, 100, 7);
    cfg_write(1, 32, 100, 9);
    cmd_smpl_depth = 16'h07D0;
    posedge_sample_trig = 1'b1;
    step();
    posedge_sample_trig = 1'b0;
    n = 0;
    while (!seg_start && n < 20) begin
      step();
      n++;
    end
    chk("rst_seg", 64'(seg_start), 64'(1));
    step();
    step();
    Pstprc_finish    = 1'b1;
    pstprc_IQ_seq_o  = 64'hA5A5_0000_1234_5678;
    pstprc_fifo_full = 1'b1;
    step();
    Pstprc_finish = 1'b0;
    step();
    step();
    chk("rst_busy_pre", 64'(busy), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk_zero_outs("midrst");
    step();
    step();
    rst_n = 1'b1;
    pstprc_fifo_full = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("post_rst_wren", 64'(pstprc_fifo_wren), 64'(0));
      chk("post_rst_busy", 64'(busy), 64'(0));
    end
    for (int i = 0; i < int'(NUM_CH); i++) begin
      m_ws[i] = 0; m_wl[i] = 0; m_dps[i] = 0;
    end
    m_num = 0;
    num_write(0);
    run_frame('h7D0, 0, -1, -1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pstprc_seq_ctrl.md
Name: pstprc_seq_ctrl

Overview:
Sequencer for the Dmod_Seg demodulation datapath.
- On each sample trigger it walks a per-channel configuration table (window start, window length, DPS word).
- For each active channel it programs Dmod_Seg, pulses its start, waits for Pstprc_finish, then pushes the IQ result with its channel index into the post-processing FIFO.
- It sits between the command decoder (configuration writes) and Dmod_Seg / result FIFO, and guards against bad windows, lost finishes and FIFO backpressure.

Parameters:
- NUM_CH, 12, number of configuration table entries (max active channels).
- WIN_W, 15, width of window start/length.
- DPS_W, 16, width of per-channel DPS word.
- IQ_W, 64, width of the IQ result word.
- TIMEOUT, 65535, cycles allowed in WAIT before abort.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- posedge_sample_trig  in  1  one-cycle pulse: capture RAM filled
- cmd_smpl_depth  in  16  valid samples in capture RAM
- pstprc_num_en  in  1  strobe: latch Pstprc_num
- Pstprc_num  in  4  number of active channels, 0 = disabled
- cfg_wr_en  in  1  table write strobe
- cfg_wr_addr  in  4  table index
- cfg_winstart  in  WIN_W  window start for table write
- cfg_winln  in  WIN_W  window length for table write
- cfg_dps  in  DPS_W  DPS word for table write
- demoWinstart_twelve  out  WIN_W  to Dmod_Seg
- demoWinln_twelve  out  WIN_W  to Dmod_Seg
- Pstprc_DPS_twelve  out  DPS_W  to Dmod_Seg
- seg_start  out  1  one-cycle start pulse to Dmod_Seg
- Pstprc_finish  in  1  Dmod_Seg done pulse
- pstprc_IQ_seq_o  in  IQ_W  Dmod_Seg result, valid with Pstprc_finish
- pstprc_fifo_wren  out  1  FIFO write enable
- pstprc_fifo_din  out  IQ_W  FIFO data
- pstprc_fifo_ch  out  4  channel index of pushed word
- pstprc_fifo_full  in  1  FIFO full
- busy  out  1  high outside IDLE
- frame_done  out  1  one-cycle pulse at end of frame
- err_clr  in  1  clears sticky error bits
- err_win  out  1  sticky: a channel was skipped for a bad window
- err_timeout  out  1  sticky: finish missing within TIMEOUT
- trig_overrun  out  1  sticky: trigger arrived while busy

Behaviour:
- **Reset:**
  - All outputs are 0; table entries are 0; num_reg is 0; state is IDLE.
  - Reset asserted mid-frame aborts immediately, with no further FIFO writes.
- **Configuration:**
  - pstprc_num_en loads num_reg, saturated to NUM_CH.
  - cfg_wr_en writes the table entry when cfg_wr_addr < NUM_CH; other addresses are ignored.
  - Both are accepted only in IDLE; while busy they are ignored.
- **States:** IDLE, LOAD, START, WAIT, PUSH, DONE.
- **IDLE:**
  - A trigger with num_reg != 0 latches depth, sets ch = 0, and moves to LOAD.
  - A trigger with num_reg == 0 is ignored.
- **LOAD:**
  - Registers table[ch] onto the three Dmod_Seg outputs; these are held stable until the next LOAD.
  - Window check uses 17-bit zero-extended arithmetic. The window is bad if winln == 0 or winstart + winln > depth.
  - Bad window: set err_win, write nothing, advance the channel.
  - Good window: go to START.
- **START:** seg_start = 1 for exactly this cycle; go to WAIT. Trigger-to-seg_start latency is 2 cycles.
- **WAIT:**
  - The timer counts from 0.
  - Pstprc_finish captures pstprc_IQ_seq_o into a holding register and moves to PUSH.
  - If the timer reaches TIMEOUT, set err_timeout and go to DONE; remaining channels are skipped.
  - Pstprc_finish outside WAIT is ignored.
- **PUSH:**
  - When !pstprc_fifo_full, assert pstprc_fifo_wren for one cycle with din = held IQ and ch = channel index.
  - While full, stay in PUSH with wren = 0, data held.
- **Channel advance:** if ch == num_reg − 1, go to DONE; else ch + 1 and LOAD.
- **DONE:** frame_done = 1 for one cycle, then IDLE.
- **Trigger while not IDLE:** set trig_overrun; the frame continues unaffected.
- **Sticky errors:**
  - err_clr clears all sticky errors.
  - If err_clr and a set event occur in the same cycle, set wins.
- **Frame output count:** a frame issues exactly (active channels − skipped) FIFO writes, or fewer on timeout.

Decomposition:
- A shared package pstprc_pkg holds:
  - the state encoding;
  - NUM_CH, WIN_W, DPS_W, IQ_W defaults;
  - the channel-entry struct {winstart, winln, dps}.
- One sub-module is natural: pstprc_cfg_table. It is the register file with write port, async reset and combinational read by ch.
- The FSM, timer and error flags stay in the top.

Test Plan:
1. **Basic frame.** num = 3; entries (0x010, 0x5DC, 0x1234), (0x100, 0x200, 0), (0, 0x7D0, 0xFFFF); depth 0x07D0; trigger.
   - seg_start at trigger+2.
   - Outputs match each entry.
   - Finish returned after 20 cycles gives 3 FIFO writes with ch 0, 1, 2 and correct IQ, then frame_done.
2. **Bad windows.** Entry1 winln = 0; entry2 = (0x700, 0x0D1) against depth 0x07D0.
   - Only ch 0 is pushed, err_win = 1, frame_done pulses.
   - err_clr clears err_win.
3. **Backpressure.** Hold pstprc_fifo_full high for 10 cycles when ch 1 finishes.
   - wren stays 0 and din/ch are stable.
   - One write occurs the cycle after full drops.
4. **Timeout.** TIMEOUT = 50; never assert finish.
   - err_timeout set at cycle 50 of WAIT, no FIFO write, frame_done, then IDLE.
5. **Trigger while busy.** Second trigger during WAIT sets trig_overrun.
   - The frame completes normally.
   - A cfg write and pstprc_num_en during the frame leave the table and num_reg unchanged.
6. **Mid-frame reset.** Assert rst_n low during PUSH with full high.
   - All outputs are 0 immediately, with no write after release.
   - num = 0 followed by a trigger stays in IDLE with busy low.
